pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 18 +
 rtl/sat_cnt.sv | 25 ++
 rtl/pipe_stage_reg.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and default widths for pipe_stage_reg
//
// Contents:
//   DATA_W_DEF    default payload width
//   CNT_W_DEF     default stall counter width
//   stage_state_e stage state; the encoding equals the number of held payloads
package pipe_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKIDF = 2'd2
    } stage_state_e;

endpackage

// File: rtl/sat_cnt.sv
// rtl/sat_cnt.sv - saturating up-counter, cleared only by reset
//
// Ports:
//   clk    clock, rising edge
//   reset  synchronous active-high clear
//   inc    count enable; ignored once the counter reaches all ones
//   q      current count
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with optional skid entry
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   in_valid     upstream payload valid
//   in_ready     stage accepts a payload this cycle
//   in_data      upstream payload
//   out_valid    out_data holds a valid payload
//   out_ready    downstream accepts this cycle (low = stall)
//   out_data     registered payload, always taken from the main register
//   flush        discard every held payload
//   occupancy    number of held payloads (0..2)
//   stall_cnt    saturating count of downstream-stall cycles
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                SKID       = 1,
    parameter logic [DATA_W-1:0] RESET_DATA = '0,
    parameter int                CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_data;
    logic              accept;
    logic              issue;
    logic              skid_load;

    assign accept    = in_valid && in_ready;
    assign issue     = out_valid && out_ready;
    assign out_valid = (state == FULL) || (state == SKIDF);
    assign out_data  = main_q;
    assign occupancy = state;

    // The skid entry is only written when a payload arrives while the main
    // register is stalled; a flush in the same cycle throws it away.
    assign skid_load = !flush && (state == FULL) && accept && !issue;

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] skid_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    skid_q <= '0;
                end else if (skid_load) begin
                    skid_q <= in_data;
                end
            end

            assign skid_data = skid_q;
            // Depends only on registered state, which breaks the ready
            // timing path back to the downstream stage.
            assign in_ready  = !reset && (state != SKIDF);
        end else begin : g_noskid
            // SKIDF is unreachable here, so this value is never loaded.
            assign skid_data = RESET_DATA;
            assign in_ready  = !reset && ((state == EMPTY) || out_ready);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= RESET_DATA;
        end else if (flush) begin
            // Data registers keep their contents; only the occupancy is dropped.
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state  <= FULL;
                        main_q <= in_data;
                    end
                end
                FULL: begin
                    if (accept && issue) begin
                        main_q <= in_data;
                    end else if (accept && (SKID != 0)) begin
                        state <= SKIDF;
                    end else if (issue) begin
                        state <= EMPTY;
                    end
                end
                SKIDF: begin
                    if (issue) begin
                        state  <= FULL;
                        main_q <= skid_data;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    sat_cnt #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid && !out_ready && !flush),
        .q     (stall_cnt)
    );

endmodule
